// File: rtl/multicycle_core_if.sv
// Unified memory port between the multicycle core and its memory.
// Latency: n/a (signal bundle only).
// Backpressure: the master holds mem_req and its qualifiers until mem_ready.
//
// Ports: mem_req/mem_we/mem_addr/mem_wdata driven by the master (core),
//        mem_rdata/mem_ready driven by the slave (memory model).
interface multicycle_core_if #(
   parameter int ADDR_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB) on one unified memory port.
// Latency (zero-wait memory): j/halt 2, beq/bne 3, R-type/ori/sw 4, lw 5 cycles.
// Backpressure: a request is held with stable address/data until mem_ready; each wait cycle adds 1.
//
// Ports: clk, rst_n (async active-low); mem (master side of multicycle_core_if);
//        pc_o current PC; halted core stopped; fault 00 none / 01 illegal / 10 misaligned;
//        dbg_sel/dbg_data combinational register-file peek (r0 reads 0).
module multicycle_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREG     = 32,
   parameter int          ADDR_W   = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   multicycle_core_if.master        mem,
   output logic [31:0]              pc_o,
   output logic                     halted,
   output logic [1:0]               fault,
   input  logic [4:0]               dbg_sel,
   output logic [31:0]              dbg_data
);
   localparam int RW = $clog2(NREG);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   state_t            state, state_n;
   logic [31:0]       pc, pc_n, ir, ir_n, a, a_n, b, b_n;
   logic [31:0]       imm, imm_n, alu, alu_n, mdr, mdr_n;
   logic              halted_q, halted_n;
   logic [1:0]        fault_q, fault_n;

   // Memory-port outputs are registered from the next state so that they are
   // all zero while reset is held, and the first fetch appears one edge later.
   logic              req_q, req_n, we_q, we_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [31:0]       wdata_q, wdata_n;

   logic [31:0]       regs [NREG];
   logic              wr_en;
   logic [RW-1:0]     wr_idx;
   logic [31:0]       wr_dat;

   logic [5:0]        op, funct;
   logic [RW-1:0]     rs_idx, rt_idx, rd_idx, dbg_idx;
   logic [31:0]       rs_val, rt_val, alu_r, ea;
   logic              hs, rtype_ok, op_ok, taken;

   assign op     = ir[31:26];
   assign funct  = ir[5:0];
   assign rs_idx = ir[21 +: RW];
   assign rt_idx = ir[16 +: RW];
   assign rd_idx = ir[11 +: RW];

   // r0 is never written, but reads are forced to zero regardless.
   assign rs_val = (rs_idx == '0) ? 32'h0 : regs[rs_idx];
   assign rt_val = (rt_idx == '0) ? 32'h0 : regs[rt_idx];

   assign dbg_idx  = dbg_sel[RW-1:0];
   assign dbg_data = (dbg_idx == '0) ? 32'h0 : regs[dbg_idx];

   assign hs       = req_q & mem.mem_ready;
   assign rtype_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
   assign op_ok    = (op == OP_RTYPE) ? rtype_ok
                   : (op inside {OP_BEQ, OP_BNE, OP_ORI, OP_LW, OP_SW});
   assign taken    = (op == OP_BEQ) ? (a == b) : (a != b);

   always_comb begin
      alu_r = 32'h0;
      case (funct)
         FN_ADD:  alu_r = a + b;
         FN_SUB:  alu_r = a - b;
         FN_AND:  alu_r = a & b;
         FN_OR:   alu_r = a | b;
         FN_SLT:  alu_r = {31'h0, $signed(a) < $signed(b)};
         default: alu_r = 32'h0;
      endcase
   end

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      ir_n     = ir;
      a_n      = a;
      b_n      = b;
      imm_n    = imm;
      alu_n    = alu;
      mdr_n    = mdr;
      halted_n = halted_q;
      fault_n  = fault_q;
      wr_en    = 1'b0;
      wr_idx   = rt_idx;
      wr_dat   = alu;
      ea       = a + imm;

      case (state)
         S_FETCH: begin
            if (hs) begin
               ir_n    = mem.mem_rdata;
               pc_n    = pc + 32'd4;
               state_n = S_DECODE;
            end
         end
         S_DECODE: begin
            a_n   = rs_val;
            b_n   = rt_val;
            imm_n = {{16{ir[15]}}, ir[15:0]};
            if (op == OP_J) begin
               pc_n    = {pc[31:28], ir[25:0], 2'b00};
               state_n = S_FETCH;
            end else if (op == OP_HALT) begin
               halted_n = 1'b1;
               state_n  = S_HALT;
            end else if (!op_ok) begin
               fault_n  = 2'b01;
               halted_n = 1'b1;
               state_n  = S_HALT;
            end else begin
               state_n = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op)
               OP_RTYPE: begin
                  alu_n   = alu_r;
                  state_n = S_WB;
               end
               OP_ORI: begin
                  alu_n   = a | {16'h0, ir[15:0]};
                  state_n = S_WB;
               end
               OP_LW, OP_SW: begin
                  alu_n = ea;
                  if (ea[1:0] != 2'b00) begin
                     fault_n  = 2'b10;
                     halted_n = 1'b1;
                     state_n  = S_HALT;
                  end else begin
                     state_n = S_MEM;
                  end
               end
               OP_BEQ, OP_BNE: begin
                  // pc already points at the delay-free successor (PC+4).
                  if (taken) pc_n = pc + {imm[29:0], 2'b00};
                  state_n = S_FETCH;
               end
               default: begin
                  // Unreachable: DECODE only forwards legal opcodes.
                  fault_n  = 2'b01;
                  halted_n = 1'b1;
                  state_n  = S_HALT;
               end
            endcase
         end
         S_MEM: begin
            if (hs) begin
               if (op == OP_LW) begin
                  mdr_n   = mem.mem_rdata;
                  state_n = S_WB;
               end else begin
                  state_n = S_FETCH;
               end
            end
         end
         S_WB: begin
            wr_en   = 1'b1;
            wr_idx  = (op == OP_RTYPE) ? rd_idx : rt_idx;
            wr_dat  = (op == OP_LW) ? mdr : alu;
            state_n = S_FETCH;
         end
         S_HALT: begin
            state_n = S_HALT;
         end
         default: begin
            state_n = S_HALT;
         end
      endcase

      req_n   = (state_n == S_FETCH) || (state_n == S_MEM);
      we_n    = (state_n == S_MEM) && (op == OP_SW);
      addr_n  = addr_q;
      wdata_n = wdata_q;
      if (state_n == S_FETCH) begin
         addr_n = pc_n[ADDR_W-1:0];
      end else if (state_n == S_MEM) begin
         addr_n = alu_n[ADDR_W-1:0];
         if (op == OP_SW) wdata_n = b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_FETCH;
         pc       <= RESET_PC;
         ir       <= 32'h0;
         a        <= 32'h0;
         b        <= 32'h0;
         imm      <= 32'h0;
         alu      <= 32'h0;
         mdr      <= 32'h0;
         halted_q <= 1'b0;
         fault_q  <= 2'b00;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         ir       <= ir_n;
         a        <= a_n;
         b        <= b_n;
         imm      <= imm_n;
         alu      <= alu_n;
         mdr      <= mdr_n;
         halted_q <= halted_n;
         fault_q  <= fault_n;
         req_q    <= req_n;
         we_q     <= we_n;
         addr_q   <= addr_n;
         wdata_q  <= wdata_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= 32'h0;
      end else if (wr_en && (wr_idx != '0)) begin
         regs[wr_idx] <= wr_dat;
      end
   end

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign pc_o          = pc;
   assign halted        = halted_q;
   assign fault         = fault_q;
endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the team's single-cycle MIPS-subset processor.
- Executes one instruction over 3–5 states: FETCH, DECODE, EXEC, MEM, WB.
- Uses a single external unified memory port with a req/ready handshake, replacing the separate internal instruction and data arrays.
- Adds new behaviour over the single-cycle core: reset, hardwired r0, jump, halt, and fault detection.
- Sits between the top-level testbench and a byte-addressed big-endian memory model.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREG, 32, number of architectural registers. Legal values are 8, 16 or 32. A register index is taken from the low log2(NREG) bits of each 5-bit field.
- ADDR_W, 32, width of mem_addr. Byte address = low ADDR_W bits of the PC or of the effective address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  out  1  memory access request; held high until mem_ready.
- mem_we  out  1  1 = word write, 0 = word read; valid while mem_req is high.
- mem_addr  out  ADDR_W  word-aligned byte address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; valid in the cycle mem_ready is high.
- mem_ready  in  1  access completes in this cycle (mem_req && mem_ready).
- pc_o  out  32  current PC.
- halted  out  1  core stopped.
- fault  out  2  00 none, 01 illegal opcode/funct, 10 misaligned lw/sw.
- dbg_sel  in  5  register index for debug read.
- dbg_data  out  32  combinational read of the register file at dbg_sel; r0 reads 0.

Behaviour:
- Reset (async, any state, including mid-handshake):
  - state=FETCH, pc=RESET_PC, all registers=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - halted=0, fault=00.
  - The first request is issued in the first cycle after rst_n deasserts.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On ready: IR<=mem_rdata, pc<=pc+4, go to DECODE.
  - Wait indefinitely while ready=0; mem_addr must stay stable while waiting.
- DECODE:
  - A<=reg[rs], B<=reg[rt], imm<=sign-extended IR[15:0].
  - j (op 02): pc<={pc[31:28], IR[25:0], 2'b00}, go to FETCH.
  - halt (op 3F): halted=1, go to HALT.
  - Unknown op, or R-type with unknown funct: fault=01, halted=1, go to HALT.
  - Otherwise go to EXEC.
- EXEC: ALUout computed and registered.
  - R-type (op 00):
    - funct 20 add: A+B, modulo 2^32, no overflow trap.
    - funct 22 sub: A-B.
    - funct 24 and: A&B.
    - funct 25 or: A|B.
    - funct 2A slt: signed compare, result 1 or 0.
    - Next state WB.
  - ori (0D): A | zero-extended IR[15:0], then WB.
  - lw (23) / sw (2B):
    - ALUout=A+imm.
    - If ALUout[1:0]!=0: fault=10, halted=1, go to HALT.
    - Otherwise go to MEM.
  - beq (04) / bne (05):
    - Taken when (A==B) for beq, or (A!=B) for bne.
    - If taken, pc<=pc+(imm<<2); pc already holds PC+4.
    - Next state FETCH.
- MEM:
  - mem_req=1, mem_addr=ALUout.
  - lw: mem_we=0; on ready MDR<=mem_rdata, go to WB.
  - sw: mem_we=1, mem_wdata=B; on ready go to FETCH.
- WB:
  - Destination: rd for R-type; rt for ori/lw.
  - Written value: ALUout, or MDR for lw.
  - A write to index 0 is discarded; r0 always reads 0.
  - Next state FETCH.
- HALT: absorbing state. No mem_req, no register or PC writes. Left only by reset.
- Latency with zero-wait memory:
  - j/halt: 2 cycles.
  - beq/bne: 3 cycles.
  - R-type/ori/sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- pc_o reflects the registered pc. pc wraps modulo 2^32.
- Regfile reads in DECODE see all writes from prior WB cycles; there is no intra-cycle forwarding requirement.

Test Plan:
- Reset mid-fetch:
  - Stimulus: assert rst_n=0 while mem_req=1 and ready=0.
  - Required response: same cycle, mem_req=0 and pc_o=RESET_PC. After release, the first request has addr=0.
- ALU sequence, zero-wait memory:
  - Stimulus: ori r1,r0,0x0005; ori r2,r0,0x0003; add r3,r1,r2; sub r4,r2,r1; slt r5,r4,r1; halt.
  - Required response: r3=8, r4=FFFFFFFE, r5=1, halted=1 at cycle 2+4*5=22.
- Load/store with wait states:
  - Stimulus: mem_ready delayed 2 cycles on every access. Program: ori r1,r0,0x10; sw r1,4(r1); lw r6,4(r1).
  - Required response: write to addr 0x14 with data 0x10; r6=0x10. lw takes 5+2+2=9 cycles.
- Branches:
  - Stimulus: bne r1,r0,+2 with r1≠0; beq r0,r0,-1 placed at 0x20.
  - Required response: bne gives pc=PC+4+8. beq gives pc=0x20 again, i.e. a loop; observe 3 iterations, then reset.
- r0 and jump:
  - Stimulus: ori r0,r0,0xFFFF; j 0x40.
  - Required response: dbg_data at dbg_sel=0 reads 0; next fetch addr=0x40.
- Faults:
  - Stimulus: lw r1,2(r0); then, separately, opcode 0x11.
  - Required response: fault=10 and fault=01 respectively; halted=1; no further mem_req; registers unchanged.
